// File: rtl/uart_mmio_responder_if.sv
// MEM-stage data bus as seen by the UART responder.
//   mem_rd / mem_wr : one-cycle load / store strobes
//   addr            : byte address
//   wdata           : store data
//   rdata           : load data, combinational from the responder
// master = pipeline MEM stage, slave = responder.
interface uart_mmio_responder_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mem_rd, mem_wr, addr, wdata, input rdata);
    modport slave  (input mem_rd, mem_wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART responder.
// Loads/stores on TXD/RXD/CON are served from the MEM-stage bus. Stores to TXD
// fill a TX FIFO drained by a small FSM that launches one byte at a time to the
// serial sender (tx_en pulse, then waits for tx_status to go busy and back to
// idle). Bytes from the receiver are captured on a rising rx_status into an RX
// FIFO. irq is a registered level request built from the enables in CON.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   bus             : MEM-stage bus (slave side)
//   irq             : level interrupt, registered
//   tx_data, tx_en  : byte and one-cycle launch pulse to the sender
//   tx_status       : sender idle (1) / shifting (0)
//   rx_data         : byte from the receiver
//   rx_status       : receiver byte-ready, captured on 0->1
module uart_mmio_responder #(
    parameter int FIFO_AW      = 2,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_responder_if.slave  bus,
    output logic                  irq,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    input  logic                  tx_status,
    input  logic [7:0]            rx_data,
    input  logic                  rx_status
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0]      TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]      TMR_MAX  = TW'(BUSY_TIMEOUT);

    // ---------------- state ----------------
    logic [DEPTH-1:0][7:0] tx_mem_q, tx_mem_d;
    logic [FIFO_AW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;

    logic [DEPTH-1:0][7:0] rx_mem_q, rx_mem_d;
    logic [FIFO_AW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_en_q, tx_en_d;

    logic                  txie_q, txie_d, rxie_q, rxie_d;
    logic                  rx_ovf_q, rx_ovf_d, tx_drop_q, tx_drop_d;
    logic                  rx_prev_q, rx_prev_d;
    logic                  irq_q, irq_d;

    // ---------------- decode ----------------
    logic hit_txd, hit_rxd, hit_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign hit_txd = (bus.addr == ADDR_TXD);
    assign hit_rxd = (bus.addr == ADDR_RXD);
    assign hit_con = (bus.addr == ADDR_CON);
    assign wr_txd  = bus.mem_wr & hit_txd;
    assign wr_con  = bus.mem_wr & hit_con;
    assign rd_rxd  = bus.mem_rd & hit_rxd;
    assign rd_con  = bus.mem_rd & hit_con;

    // Only bytes and a few control bits of wdata are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^{bus.wdata[31:8], bus.wdata[4:2]};

    // ---------------- status ----------------
    logic tx_full, tx_empty, rx_full, rx_nonempty, tx_idle;
    assign tx_full     = (tx_cnt_q == CNT_FULL);
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == CNT_FULL);
    assign rx_nonempty = (rx_cnt_q != '0);
    assign tx_idle     = tx_empty & (state_q == ST_IDLE);

    // ---------------- FIFO control ----------------
    logic tx_push, tx_pop, rx_edge, rx_push, rx_pop;
    assign tx_push = wr_txd & ~tx_full;
    assign tx_pop  = (state_q == ST_IDLE) & ~tx_empty;
    assign rx_edge = rx_status & ~rx_prev_q;
    assign rx_pop  = rd_rxd & rx_nonempty;
    // A pop in the same cycle frees the slot the push needs.
    assign rx_push = rx_edge & (~rx_full | rx_pop);

    // ---------------- load data ----------------
    logic [31:0] rdata_c;
    always_comb begin
        rdata_c = '0;
        if (rd_rxd && rx_nonempty) begin
            rdata_c = {24'b0, rx_mem_q[rx_rp_q]};
        end else if (rd_con) begin
            rdata_c = {25'b0, tx_drop_q, rx_ovf_q, tx_idle, tx_full,
                       rx_nonempty, rxie_q, txie_q};
        end
    end
    assign bus.rdata = rdata_c;

    // ---------------- next state ----------------
    logic tx_idle_d;

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wp_d   = tx_wp_q;
        tx_rp_d   = tx_rp_q;
        tx_cnt_d  = tx_cnt_q;
        rx_mem_d  = rx_mem_q;
        rx_wp_d   = rx_wp_q;
        rx_rp_d   = rx_rp_q;
        rx_cnt_d  = rx_cnt_q;
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        txie_d    = txie_q;
        rxie_d    = rxie_q;
        rx_ovf_d  = rx_ovf_q;
        tx_drop_d = tx_drop_q;
        rx_prev_d = rx_status;

        // CON write: enables load, status bits are write-1-to-clear.
        if (wr_con) begin
            txie_d = bus.wdata[0];
            rxie_d = bus.wdata[1];
            if (bus.wdata[5]) rx_ovf_d  = 1'b0;
            if (bus.wdata[6]) tx_drop_d = 1'b0;
        end

        // TX FIFO write side
        if (wr_txd && tx_full) tx_drop_d = 1'b1;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = bus.wdata[7:0];
            tx_wp_d           = tx_wp_q + PTR_ONE;
        end

        // TX launch FSM
        case (state_q)
            ST_IDLE: begin
                if (tx_pop) begin
                    tx_data_d = tx_mem_q[tx_rp_q];
                    tx_en_d   = 1'b1;
                    tx_rp_d   = tx_rp_q + PTR_ONE;
                    timer_d   = '0;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // Give up if the sender never reports busy.
                if (!tx_status)                state_d = ST_WAIT_DONE;
                else if (timer_q == TMR_MAX)   state_d = ST_IDLE;
                else                           timer_d = timer_q + TMR_ONE;
            end
            ST_WAIT_DONE: begin
                if (tx_status) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        // RX FIFO
        if (rx_edge && rx_full && !rx_pop) rx_ovf_d = 1'b1;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_data;
            rx_wp_d           = rx_wp_q + PTR_ONE;
        end
        if (rx_pop) rx_rp_d = rx_rp_q + PTR_ONE;

        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // irq follows next-state values so CON writes and pops show up at their edge.
    assign tx_idle_d = (tx_cnt_d == '0) & (state_d == ST_IDLE);
    assign irq_d     = (rxie_d & (rx_cnt_d != '0)) | (txie_d & tx_idle_d);

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_mem_q  <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_mem_q  <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            txie_q    <= 1'b0;
            rxie_q    <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            rx_prev_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tx_mem_q  <= tx_mem_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_mem_q  <= rx_mem_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            txie_q    <= txie_d;
            rxie_q    <= rxie_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_drop_q <= tx_drop_d;
            rx_prev_q <= rx_prev_d;
            irq_q     <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: scoreboard queues of expected
// TX bytes (checked by a sender model on each tx_en) and expected RX bytes
// (checked on each RXD load).
module tb_uart_mmio_responder;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic       clk, reset, irq, tx_en, tx_status, rx_status;
    logic [7:0] tx_data, rx_data;

    uart_mmio_responder_if bus_if();

    uart_mmio_responder #(.FIFO_AW(2), .BUSY_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .irq       (irq),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_status (rx_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];
    int   busy_cycles = 10;
    logic hold_busy   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr = a; bus_if.wdata = d; bus_if.mem_wr = 1'b1;
        @(posedge clk); #1;
        bus_if.mem_wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr = a; bus_if.mem_rd = 1'b1;
        #2 d = bus_if.rdata;
        @(posedge clk); #1;
        bus_if.mem_rd = 1'b0; bus_if.addr = '0;
    endtask

    task automatic chk_con(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(CON, d);
        chk(tag, d, exp);
    endtask

    // RXD load checked against the scoreboard; empty scoreboard means 0.
    task automatic rd_rxd(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (rx_exp.size() != 0) ? {24'b0, rx_exp.pop_front()} : 32'h0;
        bus_rd(RXD, d);
        chk(tag, d, e);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b; rx_status = 1'b1;
        @(posedge clk); #1;
        rx_status = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_tx_drain(input string tag);
        for (int i = 0; i < 400 && tx_exp.size() != 0; i++) @(posedge clk);
        #1 chk(tag, 32'(tx_exp.size()), 32'h0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Sender model: checks each launched byte, goes busy, returns idle later.
    initial begin
        tx_status = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tx_en) begin
                if (tx_exp.size() == 0) chk("tx_en_unexp", {31'b0, tx_en}, 32'h0);
                else                    chk("tx_byte", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
                tx_status = 1'b0;
                @(posedge clk); #1;
                chk("tx_en_pulse", {31'b0, tx_en}, 32'h0);
                repeat (busy_cycles) @(posedge clk);
                while (hold_busy) @(posedge clk);
                #1 tx_status = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b0;
        bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b0;
        bus_if.addr = '0; bus_if.wdata = '0;
        rx_data = '0; rx_status = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_en", {31'b0, tx_en}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_tx_data", {24'b0, tx_data}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        bus_if.addr = CON;
        #1 chk("rdata_no_rd", bus_if.rdata, 0);
        bus_if.addr = '0;
        @(posedge clk); #1;
        chk_con("con_reset", 32'h10);
        bus_rd(TXD, d);          chk("txd_read", d, 0);
        bus_rd(32'h4000_0024, d); chk("unmapped_read", d, 0);
        bus_wr(32'h4000_0024, 32'h3);
        bus_wr(RXD, 32'h3);
        chk_con("con_after_bad_wr", 32'h10);

        // ---- single TX byte, latency and pulse ----
        busy_cycles = 10;
        tx_exp.push_back(8'h41);
        bus_wr(TXD, 32'h41);
        chk("tx_en_edgeN", {31'b0, tx_en}, 0);
        @(posedge clk); #1;
        chk("tx_en_N1", {31'b0, tx_en}, 1);
        chk("tx_data_N1", {24'b0, tx_data}, 32'h41);
        repeat (3) @(posedge clk);
        #1;
        chk_con("con_tx_busy", 32'h00);
        wait_tx_drain("tx1_drain");
        chk_con("con_tx1_idle", 32'h10);

        // ---- burst of 5 with sender held busy, then a 6th into a full FIFO ----
        busy_cycles = 3;
        hold_busy   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tx_exp.push_back(8'(i));
            bus_wr(TXD, 32'(i));
        end
        chk_con("con_burst_full", 32'h08);
        bus_wr(TXD, 32'h06);
        chk_con("con_drop_set", 32'h48);
        bus_wr(CON, 32'h40);
        chk_con("con_drop_clr", 32'h08);
        hold_busy = 1'b0;
        wait_tx_drain("burst_drain");
        chk_con("con_burst_idle", 32'h10);

        // ---- RX two bytes, in order, then empty ----
        rx_exp.push_back(8'h5A); rx_byte(8'h5A);
        rx_exp.push_back(8'hA5); rx_byte(8'hA5);
        chk_con("con_rx_nonempty", 32'h14);
        rd_rxd("rxd_1");
        rd_rxd("rxd_2");
        rd_rxd("rxd_empty");
        chk_con("con_rx_empty", 32'h10);

        // ---- RX overflow, then same-cycle push/pop on full ----
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx_exp.push_back(8'(8'h11 + i));
            rx_byte(8'(8'h11 + i));
        end
        chk_con("con_rx_ovf", 32'h34);
        bus_wr(CON, 32'h20);
        chk_con("con_ovf_clr", 32'h14);
        d = {24'b0, rx_exp.pop_front()};
        rx_exp.push_back(8'h16);
        rx_data = 8'h16; rx_status = 1'b1;
        bus_if.addr = RXD; bus_if.mem_rd = 1'b1;
        #2 chk("rxd_pushpop", bus_if.rdata, d);
        @(posedge clk); #1;
        bus_if.mem_rd = 1'b0; bus_if.addr = '0; rx_status = 1'b0;
        chk_con("con_pushpop_no_ovf", 32'h14);
        for (int i = 0; i < 4; i++) rd_rxd("rxd_drain");
        rd_rxd("rxd_drain_empty");

        // ---- interrupts ----
        bus_wr(CON, 32'h2);
        chk("irq_rxie_empty", {31'b0, irq}, 0);
        rx_exp.push_back(8'h77);
        rx_data = 8'h77; rx_status = 1'b1;
        @(posedge clk); #1;
        chk("irq_rx_edge", {31'b0, irq}, 1);
        rx_status = 1'b0;
        @(posedge clk); #1;
        rd_rxd("rxd_irq");
        chk("irq_after_pop", {31'b0, irq}, 0);
        bus_wr(CON, 32'h1);
        chk("irq_txie_idle", {31'b0, irq}, 1);
        bus_wr(CON, 32'h0);
        chk("irq_off", {31'b0, irq}, 0);

        // ---- reset in WAIT_DONE with two bytes queued ----
        bus_wr(CON, 32'h2);
        rx_byte(8'h99);
        chk("irq_pre_rst", {31'b0, irq}, 1);
        hold_busy = 1'b1;
        tx_exp.push_back(8'h31);
        bus_wr(TXD, 32'h31);
        bus_wr(TXD, 32'h32);
        bus_wr(TXD, 32'h33);
        repeat (2) @(posedge clk);
        #1;
        chk_con("con_pre_rst", 32'h06);
        #3 reset = 1'b0;
        #1;
        chk("rst_mid_tx_en", {31'b0, tx_en}, 0);
        chk("rst_mid_irq", {31'b0, irq}, 0);
        chk("rst_mid_tx_data", {24'b0, tx_data}, 0);
        hold_busy = 1'b0;
        rx_exp.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_con("con_post_rst", 32'h10);
        repeat (30) @(posedge clk);
        #1;
        rd_rxd("rxd_post_rst");
        chk("tx_exp_left", 32'(tx_exp.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
